// File: rtl/output_register_bank_pkg.sv
// Shared op codes, control-block layout and byte-lane helper for the output register bank.
package output_register_bank_pkg;

  typedef enum logic [2:0] {
    OP_WRITE  = 3'd0,
    OP_SET    = 3'd1,
    OP_CLEAR  = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_PULSE  = 3'd4,
    OP_OUTPUT = 3'd5
  } op_e;

  localparam logic [2:0] CONTROL_CHANNEL = 3'd7;

  localparam logic [2:0] CTL_CONFIG       = 3'd0;
  localparam logic [2:0] CTL_COMMIT       = 3'd1;
  localparam logic [2:0] CTL_PULSE_LENGTH = 3'd2;
  localparam logic [2:0] CTL_STATUS       = 3'd3;

  localparam int CONFIG_SHADOW_BIT = 0;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/output_register_channel.sv
// One channel: shadow S, active A, pulse mask P and pulse counter; updates on the clk edge,
// output is A with P XORed on while the counter is non-zero. No backpressure.
module output_register_channel
  import output_register_bank_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               PULSE_WIDTH = 16,
  parameter logic [WIDTH-1:0] DEFAULT     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_vld,
  input  logic [2:0]             i_op,
  input  logic [WIDTH-1:0]       i_dat,
  input  logic [WIDTH-1:0]       i_mask,
  input  logic                   i_shadow,
  input  logic                   i_commit,
  input  logic                   i_pulse_vld,
  input  logic [PULSE_WIDTH-1:0] i_pulse_len,
  output logic [WIDTH-1:0]       o_shadow,
  output logic [WIDTH-1:0]       o_pulse_mask,
  output logic [WIDTH-1:0]       o_value,
  output logic                   o_pulse_active,
  output logic                   o_dirty
);

  logic [WIDTH-1:0]       r_shadow;
  logic [WIDTH-1:0]       r_active;
  logic [WIDTH-1:0]       r_pmask;
  logic [PULSE_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]       w_s_next;

  always_comb begin
    w_s_next = r_shadow;
    case (op_e'(i_op))
      OP_WRITE:  w_s_next = i_dat | (r_shadow & ~i_mask);
      OP_SET:    w_s_next = r_shadow | i_dat;
      OP_CLEAR:  w_s_next = r_shadow & ~i_dat;
      OP_TOGGLE: w_s_next = r_shadow ^ i_dat;
      default:   w_s_next = r_shadow;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= DEFAULT;
      r_active <= DEFAULT;
      r_pmask  <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_wr_vld) begin
        r_shadow <= w_s_next;
        if (!i_shadow) r_active <= w_s_next;
      end
      // commit and channel writes address different blocks, so they never coincide
      if (i_commit) r_active <= r_shadow;
      if (i_pulse_vld) begin
        r_pmask <= i_dat;
        r_cnt   <= i_pulse_len;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_shadow       = r_shadow;
  assign o_pulse_mask   = r_pmask;
  assign o_pulse_active = (r_cnt != '0);
  assign o_value        = r_active ^ (o_pulse_active ? r_pmask : '0);
  assign o_dirty        = (r_shadow != r_active);

endmodule

// File: rtl/output_register_bank.sv
// Bus-mapped bank of CHANNELS output registers with shadow/commit and timed pulses.
// Reads are combinational, writes land on the next clk edge; the bus never stalls.
module output_register_bank
  import output_register_bank_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          CHANNELS    = 4,
  parameter logic [3:0]  ADDRESS     = 4'h0,
  parameter logic [31:0] DEFAULT     = 32'b0,
  parameter int          PULSE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      peripheralBus_we,
  input  logic                      peripheralBus_oe,
  input  logic [11:0]               peripheralBus_address,
  input  logic [3:0]                peripheralBus_byteSelect,
  output logic [31:0]               peripheralBus_dataRead,
  input  logic [31:0]               peripheralBus_dataWrite,
  output logic                      requestOutput,
  output logic [CHANNELS*WIDTH-1:0] currentValue
);

  logic                   w_sel, w_we, w_oe;
  logic [2:0]             w_ch, w_op;
  logic [31:0]            w_m32, w_d32;
  logic                   w_ctl_we;
  logic                   r_config;
  logic [PULSE_WIDTH-1:0] r_pulse_len;

  logic [WIDTH-1:0] w_shadow [CHANNELS];
  logic [WIDTH-1:0] w_pmask  [CHANNELS];
  logic [WIDTH-1:0] w_value  [CHANNELS];
  logic             w_pact   [CHANNELS];
  logic             w_dirty  [CHANNELS];

  assign w_sel    = enable && (peripheralBus_address[11:8] == ADDRESS);
  assign w_we     = w_sel && peripheralBus_we && !peripheralBus_oe;
  assign w_oe     = w_sel && peripheralBus_oe && !peripheralBus_we;
  assign w_ch     = peripheralBus_address[7:5];
  assign w_op     = peripheralBus_address[4:2];
  assign w_m32    = byte_mask(peripheralBus_byteSelect);
  assign w_d32    = peripheralBus_dataWrite & w_m32;
  assign w_ctl_we = w_we && (w_ch == CONTROL_CHANNEL);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_config    <= 1'b0;
      r_pulse_len <= '0;
    end else if (w_ctl_we) begin
      if (w_op == CTL_CONFIG)
        r_config <= w_d32[CONFIG_SHADOW_BIT] | (r_config & ~w_m32[CONFIG_SHADOW_BIT]);
      if (w_op == CTL_PULSE_LENGTH)
        r_pulse_len <= w_d32[PULSE_WIDTH-1:0] | (r_pulse_len & ~w_m32[PULSE_WIDTH-1:0]);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic w_hit;
    assign w_hit = w_we && (w_ch == 3'(g));

    output_register_channel #(
      .WIDTH      (WIDTH),
      .PULSE_WIDTH(PULSE_WIDTH),
      .DEFAULT    (DEFAULT[WIDTH-1:0])
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .i_wr_vld      (w_hit && (w_op <= 3'd3)),
      .i_op          (w_op),
      .i_dat         (w_d32[WIDTH-1:0]),
      .i_mask        (w_m32[WIDTH-1:0]),
      .i_shadow      (r_config),
      .i_commit      (w_ctl_we && (w_op == CTL_COMMIT) && w_d32[g]),
      .i_pulse_vld   (w_hit && (w_op == OP_PULSE)),
      .i_pulse_len   (r_pulse_len),
      .o_shadow      (w_shadow[g]),
      .o_pulse_mask  (w_pmask[g]),
      .o_value       (w_value[g]),
      .o_pulse_active(w_pact[g]),
      .o_dirty       (w_dirty[g])
    );

    assign currentValue[g*WIDTH +: WIDTH] = w_value[g];
  end

  logic [31:0] w_status, w_rd_val;
  logic        w_rd_hit;

  always_comb begin
    w_status = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_status[n]     = w_pact[n];
      w_status[8 + n] = w_dirty[n];
    end
  end

  always_comb begin
    w_rd_val = '0;
    w_rd_hit = 1'b0;
    if (w_oe) begin
      if (w_ch == CONTROL_CHANNEL) begin
        case (w_op)
          CTL_CONFIG:       begin w_rd_hit = 1'b1; w_rd_val = {31'b0, r_config}; end
          CTL_COMMIT:       w_rd_hit = 1'b1;
          CTL_PULSE_LENGTH: begin w_rd_hit = 1'b1; w_rd_val = 32'(r_pulse_len); end
          CTL_STATUS:       begin w_rd_hit = 1'b1; w_rd_val = w_status; end
          default:          w_rd_hit = 1'b0;
        endcase
      end else begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (w_ch == 3'(n)) begin
            if (w_op <= 3'd3) begin
              w_rd_hit = 1'b1; w_rd_val = 32'(w_shadow[n]);
            end else if (w_op == OP_PULSE) begin
              w_rd_hit = 1'b1; w_rd_val = 32'(w_pmask[n]);
            end else if (w_op == OP_OUTPUT) begin
              w_rd_hit = 1'b1; w_rd_val = 32'(w_value[n]);
            end
          end
        end
      end
    end
  end

  assign peripheralBus_dataRead = w_rd_val & w_m32;
  assign requestOutput          = w_rd_hit;

  logic w_unused;
  assign w_unused = ^{peripheralBus_address[1:0], w_d32};

endmodule

// File: tb/tb_output_register_bank.sv
// Randomized + directed bench for output_register_bank against a time-stamped behavioural model.
module tb_output_register_bank;

  localparam int          W    = 8;
  localparam int          C    = 4;
  localparam int          PW   = 16;
  localparam logic [3:0]  BANK = 4'h2;
  localparam logic [31:0] DEF  = 32'h5A;

  logic         clk, rst, enable, we, oe;
  logic [11:0]  addr;
  logic [3:0]   be;
  logic [31:0]  rdata, wdata;
  logic         req;
  logic [C*W-1:0] cv;

  output_register_bank #(
    .WIDTH(W), .CHANNELS(C), .ADDRESS(BANK), .DEFAULT(DEF), .PULSE_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .peripheralBus_we(we), .peripheralBus_oe(oe),
    .peripheralBus_address(addr), .peripheralBus_byteSelect(be),
    .peripheralBus_dataRead(rdata), .peripheralBus_dataWrite(wdata),
    .requestOutput(req), .currentValue(cv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: pulses are kept as the edge number at which they expire.
  logic [W-1:0]  mS [C];
  logic [W-1:0]  mA [C];
  logic [W-1:0]  mP [C];
  longint        mEnd [C];
  longint        edges = 0;
  logic          mCfg;
  logic [PW-1:0] mLen;

  function automatic logic [31:0] lanes(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = b[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic bit pulsing(input int n);
    return edges < mEnd[n];
  endfunction

  function automatic logic [W-1:0] exp_cv(input int n);
    return mA[n] ^ (pulsing(n) ? mP[n] : '0);
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] m, d;
    int ch, op;
    edges++;
    m  = lanes(be);
    d  = wdata & m;
    ch = int'(addr[7:5]);
    op = int'(addr[4:2]);
    if (rst) begin
      for (int n = 0; n < C; n++) begin
        mS[n] = DEF[W-1:0]; mA[n] = DEF[W-1:0]; mP[n] = '0; mEnd[n] = 0;
      end
      mCfg = 0; mLen = '0;
    end else if (enable && addr[11:8] == BANK && we && !oe) begin
      if (ch < C && op <= 3) begin
        case (op)
          0: mS[ch] = d[W-1:0] | (mS[ch] & ~m[W-1:0]);
          1: mS[ch] = mS[ch] | d[W-1:0];
          2: mS[ch] = mS[ch] & ~d[W-1:0];
          default: mS[ch] = mS[ch] ^ d[W-1:0];
        endcase
        if (!mCfg) mA[ch] = mS[ch];
      end else if (ch < C && op == 4) begin
        mP[ch]   = d[W-1:0];
        mEnd[ch] = edges + longint'(mLen);
      end else if (ch == 7) begin
        if (op == 0) mCfg = d[0] | (mCfg & ~m[0]);
        if (op == 1) for (int n = 0; n < C; n++) if (d[n]) mA[n] = mS[n];
        if (op == 2) mLen = d[PW-1:0] | (mLen & ~m[PW-1:0]);
      end
    end
  end

  function automatic logic [32:0] exp_rd();
    logic [31:0] v;
    int ch, op;
    bit hit;
    v = '0; hit = 0;
    ch = int'(addr[7:5]);
    op = int'(addr[4:2]);
    if (enable && addr[11:8] == BANK && oe && !we) begin
      if (ch == 7) begin
        hit = (op <= 3);
        if (op == 0) v = {31'b0, mCfg};
        if (op == 2) v = 32'(mLen);
        if (op == 3) for (int n = 0; n < C; n++) begin
          v[n] = pulsing(n); v[8+n] = (mS[n] != mA[n]);
        end
      end else if (ch < C) begin
        hit = (op <= 5);
        if (op <= 3) v = 32'(mS[ch]);
        if (op == 4) v = 32'(mP[ch]);
        if (op == 5) v = 32'(exp_cv(ch));
      end
    end
    return {hit, hit ? (v & lanes(be)) : 32'b0};
  endfunction

  always @(negedge clk) begin
    if (chk_on)
      for (int n = 0; n < C; n++) check($sformatf("cv%0d", n), 32'(cv[n*W +: W]), 32'(exp_cv(n)));
  end

  task automatic wr(input logic [2:0] ch, input logic [2:0] op, input logic [31:0] dat,
                    input logic [3:0] b = 4'hF);
    @(negedge clk);
    enable = 1; we = 1; oe = 0; addr = {BANK, ch, op, 2'b00}; be = b; wdata = dat;
    @(posedge clk);
    #1 we = 0;
  endtask

  task automatic rd(input logic [2:0] ch, input logic [2:0] op, input logic [3:0] b = 4'hF,
                    input logic both = 0);
    logic [32:0] e;
    @(negedge clk);
    enable = 1; we = both; oe = 1; addr = {BANK, ch, op, 2'b00}; be = b; wdata = $urandom;
    #2;
    e = exp_rd();
    check("rd_req", {31'b0, req}, {31'b0, e[32]});
    check("rd_dat", rdata, e[31:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      we = 0; oe = 0;
    end
  endtask

  initial begin
    rst = 1; enable = 0; we = 0; oe = 0; addr = '0; be = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 chk_on = 1;
    @(negedge clk) rst = 0;

    // reset state
    for (int n = 0; n < C; n++) begin
      rd(3'(n), 3'd5);
      check("rst_out", rdata, DEF);
    end
    rd(3'd7, 3'd3);
    check("rst_status", rdata, 32'h0);

    // immediate mode
    wr(3'd1, 3'd0, 32'hA5, 4'b0001);
    wr(3'd1, 3'd2, 32'h0F);
    rd(3'd1, 3'd0);
    check("imm_s", rdata, 32'hA0);
    check("imm_cv", 32'(cv[W +: W]), 32'hA0);

    // shadow mode and commit
    wr(3'd7, 3'd0, 32'h1);
    wr(3'd0, 3'd0, 32'h11);
    wr(3'd2, 3'd0, 32'h22);
    rd(3'd7, 3'd3);
    check("sh_dirty", {29'b0, rdata[10:8]}, 32'h5);
    wr(3'd7, 3'd1, 32'h5);
    check("cm_ch0", 32'(cv[0 +: W]), 32'h11);
    check("cm_ch2", 32'(cv[2*W +: W]), 32'h22);
    rd(3'd7, 3'd3);
    check("cm_clean", {25'b0, rdata[14:8]}, 32'h0);

    // pulse, then re-pulse during an active pulse
    wr(3'd7, 3'd0, 32'h0);
    wr(3'd0, 3'd0, 32'h00);
    wr(3'd7, 3'd2, 32'h3);
    wr(3'd0, 3'd4, 32'h81);
    check("pl_on", 32'(cv[0 +: W]), 32'h81);
    rd(3'd7, 3'd3);
    idle(4);
    check("pl_off", 32'(cv[0 +: W]), 32'h00);
    wr(3'd0, 3'd4, 32'h81);
    idle(1);
    wr(3'd0, 3'd4, 32'h02);
    idle(5);
    wr(3'd7, 3'd2, 32'h0);
    wr(3'd1, 3'd4, 32'hFF);

    // address boundaries and we/oe collision
    wr(3'd5, 3'd0, 32'hFF);
    wr(3'd0, 3'd6, 32'hFF);
    rd(3'd5, 3'd0);
    rd(3'd0, 3'd6);
    rd(3'd0, 3'd0, 4'hF, 1'b1);
    check("both_req", {31'b0, req}, 32'h0);
    idle(1);
    rd(3'd0, 3'd0);

    // reset mid-pulse with pending shadow data
    wr(3'd7, 3'd2, 32'd10);
    wr(3'd7, 3'd0, 32'h1);
    wr(3'd3, 3'd0, 32'hEE);
    wr(3'd1, 3'd4, 32'h0F);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int n = 0; n < C; n++) check("rst_mid", 32'(cv[n*W +: W]), DEF);
    rd(3'd7, 3'd3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [2:0] ch, op;
      logic [31:0] dat;
      ch  = 3'($urandom_range(0, 7));
      op  = (ch == 3'd7) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
      dat = $urandom;
      if (ch == 3'd7 && op == 3'd2) dat = $urandom_range(0, 6);
      if ($urandom_range(0, 99) < 3) begin
        @(negedge clk) rst = 1;
        @(posedge clk);
        #1 rst = 0;
      end else if ($urandom_range(0, 9) < 6) begin
        wr(ch, op, dat, 4'($urandom));
        if ($urandom_range(0, 9) == 0) begin
          @(negedge clk);
          enable = 0; we = 1; addr = {BANK, 3'd0, 3'd3, 2'b00}; wdata = $urandom;
          @(posedge clk);
          #1 we = 0; enable = 1;
        end
      end else begin
        rd(ch, op, 4'($urandom), $urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/output_register_bank.md
# output_register_bank

Parametrised bank of CHANNELS output registers on the peripheral bus. Each channel adds a shadow/commit double buffer and a self-timed pulse (temporary XOR) mode to the usual write/set/clear/toggle operations. It sits between the peripheral bus and GPIO/control outputs that need glitch-free multi-channel updates or timed strobes.

## Interface
- WIDTH, 32: bits per channel, 1..32; upper data bits ignored on write, read as 0.
- CHANNELS, 4: number of channels, 1..7.
- ADDRESS, 4'h0: bank select, compared with address[11:8].
- DEFAULT, 32'b0: reset value of every channel's shadow and active register (low WIDTH bits).
- PULSE_WIDTH, 16: width of the pulse length register and the per-channel counters.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  bank enable from the peripheral decoder.
- peripheralBus_we  in  1  write strobe.
- peripheralBus_oe  in  1  read strobe.
- peripheralBus_address  in  12  byte address.
- peripheralBus_byteSelect  in  4  byte lanes.
- peripheralBus_dataRead  out  32  read data; 0 when not reading.
- peripheralBus_dataWrite  in  32  write data.
- requestOutput  out  1  high while this bank drives dataRead.
- currentValue  out  CHANNELS*WIDTH  channel n is in bits [n*WIDTH +: WIDTH].

## Operation
- Decode:
  - Selected when enable and address[11:8]==ADDRESS.
  - channel = address[7:5]; op = address[4:2].
  - Channel 7 is the control block. Channels CHANNELS..6 are unmapped.
  - we = sel & we & !oe; oe = sel & oe & !we.
- Byte mask m expands byteSelect to 32 bits. d = dataWrite & m.
- Channel ops, all applied to the shadow register S:
  - op0 WRITE: S = d | (S & ~m).
  - op1 SET: S |= d.
  - op2 CLEAR: S &= ~d.
  - op3 TOGGLE: S ^= d.
  - op4 PULSE: loads pulse mask P = d and counter = PULSE_LENGTH. Does not touch S.
  - op5 OUTPUT: read-only; returns currentValue of the channel.
  - op6, op7: reserved.
- Reads: op0–op3 return S; op4 returns P.
- Active register A:
  - CONFIG.shadow=0: any write op0–op3 also sets A to the new S in the same edge.
  - CONFIG.shadow=1: A changes only on COMMIT.
- currentValue = A ^ (pulse active ? P : 0). A pulse is active while counter != 0.
- Control block (channel 7):
  - op0 CONFIG: bit0 = shadow mode. RW, reset 0.
  - op1 COMMIT: write-only. For each n < CHANNELS with d[n]=1, A_n <= S_n. Reads return 0.
  - op2 PULSE_LENGTH: RW, reset 0.
  - op3 STATUS: read-only. Bits [6:0] = pulse active per channel; bits [14:8] = S_n != A_n per channel.
  - op4–op7: reserved.
- Unmapped channels and reserved ops: writes are ignored; requestOutput=0 and dataRead=0.
- Mapped reads: dataRead = value & m; requestOutput=1. Otherwise dataRead=0 and requestOutput=0.
- Clearing CONFIG.shadow does not copy S to A. A follows S again from the next write to that channel.

## Timing
- Reset: S=A=DEFAULT, P=0, counters=0, CONFIG=0, PULSE_LENGTH=0. currentValue=DEFAULT on every channel.
- Reads are combinational in the same cycle as oe.
- Writes take effect at the first clk edge with we high.
- Pulse:
  - A PULSE write at edge N makes the XOR visible in cycles N+1 .. N+PULSE_LENGTH. It is removed at edge N+PULSE_LENGTH.
  - PULSE_LENGTH=0 loads a zero counter, so there is no visible effect.
  - PULSE to a channel whose pulse is already active replaces P and reloads the counter.
  - Changing PULSE_LENGTH does not affect pulses already running.
- COMMIT or immediate-mode writes during an active pulse update A. The pulse stays applied on top of the new A.
- rst mid-pulse or mid-shadow-update returns everything to the reset values at that edge.

## Structure
- Package output_register_bank_pkg holds:
  - op codes: OP_WRITE..OP_OUTPUT.
  - CONTROL_CHANNEL = 3'd7.
  - control op codes.
  - CONFIG_SHADOW_BIT = 0.
- Sub-module output_register_channel holds S, A, P and the pulse counter for one channel, instantiated CHANNELS times by a generate loop.
- The top level owns decode, the control registers and the read mux.

## Test plan
- Reset, WIDTH=8: read op5 on each channel -> DEFAULT. STATUS -> 0.
- Immediate mode: WRITE ch1 0xA5 with byteSelect=4'b0001, then CLEAR 0x0F -> currentValue ch1 = 0xA0 one edge after each write. Read op0 -> 0xA0.
- Shadow mode: CONFIG=1, WRITE ch0=0x11 and ch2=0x22 -> outputs unchanged, STATUS[10:8]=3'b101. COMMIT 0x5 -> both outputs update on the same edge; STATUS[14:8] -> 0.
- Pulse: PULSE_LENGTH=3, ch0 A=0x00, PULSE 0x81 -> currentValue ch0 = 0x81 for exactly 3 cycles, then 0x00. STATUS[0] high for those 3 cycles only. Re-pulse 0x02 at cycle 2 -> 0x02 for 3 more cycles.
- Address boundaries, CHANNELS=4: write/read to channel 5 and to ch0 op6 -> no state change, requestOutput=0. Read with we and oe both high -> no write, requestOutput=0.
- Reset asserted mid-pulse with pending shadow data -> next cycle every currentValue=DEFAULT and STATUS=0.
